// File: rtl/deque_pkg.sv
// Shared types for the move deque and its controller.
// Error codes and the 2-bit move encoding.
package deque_pkg;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_ILLEGAL   = 2'd3
    } err_t;

    typedef logic [1:0] move_t;

endpackage

// File: rtl/deque_ptr.sv
// Circular index register for the deque head or tail.
// Wraps mod DEPTH, which is a power of two.
module deque_ptr #(
    parameter int DEPTH = 256,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    input  logic          dec,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end else if (dec) begin
            ptr <= ptr - PW'(1);
        end
    end

endmodule

// File: rtl/move_deque.sv
// Circular-buffer deque of moves with push/pop at both ends,
// registered pop data, error reporting and front/back peeks.
module move_deque
    import deque_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 256,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             our_reset,
    input  logic             clear,
    input  logic             push_back,
    input  logic             push_front,
    input  logic             pop_back,
    input  logic             pop_front,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] front_data,
    output logic [WIDTH-1:0] back_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output err_t             err
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_m1;
    logic [PW-1:0]    tail_m1;
    logic [PW-1:0]    waddr;
    logic [WIDTH-1:0] rdata;

    logic illegal;
    logic any_push;
    logic any_pop;
    logic pop_ok;
    logic push_ok;
    logic head_inc;
    logic head_dec;
    logic tail_inc;
    logic tail_dec;
    err_t err_d;

    assign head_m1    = head - PW'(1);
    assign tail_m1    = tail - PW'(1);
    assign front_data = mem[head];
    assign back_data  = mem[tail_m1];
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);

    always_comb begin
        illegal  = (push_back & push_front) | (pop_back & pop_front);
        any_push = push_back | push_front;
        any_pop  = pop_back | pop_front;
        pop_ok   = !illegal && any_pop && !empty;
        // a pop in the same cycle frees a slot for a push on full
        push_ok  = !illegal && any_push && (!full || pop_ok);

        err_d = ERR_NONE;
        if (illegal) begin
            err_d = ERR_ILLEGAL;
        end else if (any_pop && empty) begin
            err_d = ERR_UNDERFLOW;
        end else if (any_push && full && !pop_ok) begin
            err_d = ERR_OVERFLOW;
        end

        rdata = pop_front ? mem[head] : mem[tail_m1];

        // same-end push+pop overwrites the slot just popped
        if (push_back) begin
            waddr = (pop_ok && pop_back) ? tail_m1 : tail;
        end else begin
            waddr = (pop_ok && pop_front) ? head : head_m1;
        end

        head_inc = pop_ok && pop_front && !(push_ok && push_front);
        head_dec = push_ok && push_front && !(pop_ok && pop_front);
        tail_inc = push_ok && push_back && !(pop_ok && pop_back);
        tail_dec = pop_ok && pop_back && !(push_ok && push_back);
    end

    deque_ptr #(.DEPTH(DEPTH)) u_head (
        .clk   (Clk),
        .rst   (our_reset),
        .clear (clear),
        .inc   (head_inc),
        .dec   (head_dec),
        .ptr   (head)
    );

    deque_ptr #(.DEPTH(DEPTH)) u_tail (
        .clk   (Clk),
        .rst   (our_reset),
        .clear (clear),
        .inc   (tail_inc),
        .dec   (tail_dec),
        .ptr   (tail)
    );

    always_ff @(posedge Clk) begin
        if (!our_reset && !clear && push_ok) begin
            mem[waddr] <= din;
        end
    end

    always_ff @(posedge Clk) begin
        if (our_reset) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= ERR_NONE;
        end else if (clear) begin
            count      <= '0;
            dout_valid <= 1'b0;
            err        <= ERR_NONE;
        end else begin
            dout_valid <= pop_ok;
            err        <= err_d;
            if (pop_ok) begin
                dout <= rdata;
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_move_deque.sv
// Directed and model-based checks of move_deque at DEPTH=4.
module tb_move_deque;
    import deque_pkg::*;

    logic       Clk;
    logic       our_reset;
    logic       clear;
    logic       push_back;
    logic       push_front;
    logic       pop_back;
    logic       pop_front;
    logic [1:0] din;
    logic [1:0] dout;
    logic       dout_valid;
    logic [1:0] front_data;
    logic [1:0] back_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    err_t       err;

    int n_checks = 0;
    int n_fail   = 0;

    move_deque #(.WIDTH(2), .DEPTH(4)) dut (
        .Clk        (Clk),
        .our_reset  (our_reset),
        .clear      (clear),
        .push_back  (push_back),
        .push_front (push_front),
        .pop_back   (pop_back),
        .pop_front  (pop_front),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .front_data (front_data),
        .back_data  (back_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .err        (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc(input logic pb, input logic pf, input logic qb,
                       input logic qf, input logic [1:0] d);
        push_back = pb; push_front = pf;
        pop_back = qb; pop_front = qf; din = d;
        @(posedge Clk); #1;
        push_back = 0; push_front = 0;
        pop_back = 0; pop_front = 0; din = 0;
    endtask

    task automatic do_reset();
        our_reset = 1;
        @(posedge Clk); #1;
        our_reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", dout_valid); end
        n_checks++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL reset_err got %0d want 0", err); end
        n_checks++; if (dout !== 2'd0) begin n_fail++; $display("FAIL reset_dout got %0d want 0", dout); end
    endtask

    task automatic test_fifo();
        logic [1:0] exp_v[3] = '{2'd1, 2'd2, 2'd3};
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, exp_v[i]);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fifo_count got %0d want 3", count); end
        n_checks++; if (front_data !== 2'd1) begin n_fail++; $display("FAIL fifo_front got %0d want 1", front_data); end
        n_checks++; if (back_data !== 2'd3) begin n_fail++; $display("FAIL fifo_back got %0d want 3", back_data); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_checks++; if (dout_valid !== 1'b1 || dout !== exp_v[i]) begin
                n_fail++; $display("FAIL fifo_pop%0d got v=%b d=%0d want v=1 d=%0d", i, dout_valid, dout, exp_v[i]);
            end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fifo_empty got %b want 1", empty); end
        cyc(0, 1, 0, 0, 2'd1);
        cyc(0, 1, 0, 0, 2'd2);
        cyc(0, 0, 0, 1, 0);
        n_checks++; if (dout !== 2'd2 || dout_valid !== 1'b1) begin
            n_fail++; $display("FAIL lifo_pop got v=%b d=%0d want v=1 d=2", dout_valid, dout);
        end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL lifo_count got %0d want 1", count); end
    endtask

    task automatic test_full();
        logic [1:0] v[4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, v[i]);
        n_checks++; if (full !== 1'b1 || count !== 3'd4) begin
            n_fail++; $display("FAIL full_set got full=%b cnt=%0d want 1/4", full, count);
        end
        cyc(1, 0, 0, 0, 2'd2);
        n_checks++; if (err !== ERR_OVERFLOW) begin n_fail++; $display("FAIL overflow_err got %0d want 2", err); end
        n_checks++; if (count !== 3'd4 || back_data !== 2'd1) begin
            n_fail++; $display("FAIL overflow_state got cnt=%0d back=%0d want 4/1", count, back_data);
        end
        cyc(1, 0, 0, 1, 2'd3);
        n_checks++; if (dout !== 2'd1 || dout_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_xpop got v=%b d=%0d want v=1 d=1", dout_valid, dout);
        end
        n_checks++; if (full !== 1'b1 || err !== ERR_NONE) begin
            n_fail++; $display("FAIL full_xpop_flags got full=%b err=%0d want 1/0", full, err);
        end
        n_checks++; if (front_data !== 2'd2 || back_data !== 2'd3) begin
            n_fail++; $display("FAIL full_xpop_peek got f=%0d b=%0d want 2/3", front_data, back_data);
        end
        cyc(1, 0, 1, 0, 2'd0);
        n_checks++; if (dout !== 2'd3 || back_data !== 2'd0 || count !== 3'd4) begin
            n_fail++; $display("FAIL same_end got d=%0d b=%0d cnt=%0d want 3/0/4", dout, back_data, count);
        end
        clear = 1;
        cyc(1, 0, 0, 0, 2'd1);
        clear = 0;
        n_checks++; if (empty !== 1'b1 || count !== 3'd0) begin
            n_fail++; $display("FAIL clear got empty=%b cnt=%0d want 1/0", empty, count);
        end
        n_checks++; if (dout !== 2'd3 || dout_valid !== 1'b0 || err !== ERR_NONE) begin
            n_fail++; $display("FAIL clear_out got d=%0d v=%b err=%0d want 3/0/0", dout, dout_valid, err);
        end
    endtask

    task automatic test_underflow();
        cyc(0, 0, 1, 0, 0);
        n_checks++; if (err !== ERR_UNDERFLOW || dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL underflow got err=%0d v=%b want 1/0", err, dout_valid);
        end
        cyc(1, 0, 1, 0, 2'd2);
        n_checks++; if (err !== ERR_UNDERFLOW || count !== 3'd1) begin
            n_fail++; $display("FAIL uf_push got err=%0d cnt=%0d want 1/1", err, count);
        end
        n_checks++; if (back_data !== 2'd2 || dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL uf_push_peek got b=%0d v=%b want 2/0", back_data, dout_valid);
        end
        cyc(0, 0, 0, 1, 0);
        n_checks++; if (dout !== 2'd2 || empty !== 1'b1) begin
            n_fail++; $display("FAIL uf_drain got d=%0d empty=%b want 2/1", dout, empty);
        end
    endtask

    task automatic test_wrap_illegal();
        do_reset();
        cyc(0, 1, 0, 0, 2'd3);
        n_checks++; if (dut.head !== 2'd3 || front_data !== 2'd3) begin
            n_fail++; $display("FAIL wrap_front got head=%0d f=%0d want 3/3", dut.head, front_data);
        end
        cyc(1, 0, 0, 0, 2'd1);
        cyc(1, 1, 0, 0, 2'd2);
        n_checks++; if (err !== ERR_ILLEGAL || count !== 3'd2) begin
            n_fail++; $display("FAIL ill_push got err=%0d cnt=%0d want 3/2", err, count);
        end
        n_checks++; if (front_data !== 2'd3 || back_data !== 2'd1) begin
            n_fail++; $display("FAIL ill_push_peek got f=%0d b=%0d want 3/1", front_data, back_data);
        end
        cyc(0, 0, 1, 1, 0);
        n_checks++; if (err !== ERR_ILLEGAL || dout_valid !== 1'b0 || count !== 3'd2) begin
            n_fail++; $display("FAIL ill_pop got err=%0d v=%b cnt=%0d want 3/0/2", err, dout_valid, count);
        end
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL err_clear got %0d want 0", err); end
    endtask

    task automatic test_reset_pop();
        cyc(0, 0, 0, 1, 0);
        n_checks++; if (dout !== 2'd3) begin n_fail++; $display("FAIL pre_rst_pop got %0d want 3", dout); end
        our_reset = 1; pop_front = 1;
        @(posedge Clk); #1;
        our_reset = 0; pop_front = 0;
        n_checks++; if (dout_valid !== 1'b0 || dout !== 2'd0 || count !== 3'd0) begin
            n_fail++; $display("FAIL rst_pop got v=%b d=%0d cnt=%0d want 0/0/0", dout_valid, dout, count);
        end
    endtask

    task automatic test_random();
        logic [1:0] q[$];
        logic [1:0] d;
        logic [1:0] exp_d;
        int pk;
        int ok;
        do_reset();
        exp_d = 0;
        for (int i = 0; i < 200; i++) begin
            pk = $urandom_range(0, 2);
            ok = $urandom_range(0, 2);
            d  = 2'($urandom_range(0, 3));
            if (q.size() == 0) ok = 0;
            if (q.size() == 4 && ok == 0) pk = 0;
            if (ok == 1) exp_d = q.pop_back();
            if (ok == 2) exp_d = q.pop_front();
            if (pk == 1) q.push_back(d);
            if (pk == 2) q.push_front(d);
            cyc(pk == 1, pk == 2, ok == 1, ok == 2, d);
            n_checks++; if (dout_valid !== (ok != 0) || (ok != 0 && dout !== exp_d)) begin
                n_fail++; $display("FAIL rnd_pop%0d got v=%b d=%0d want v=%0d d=%0d", i, dout_valid, dout, ok != 0, exp_d);
            end
            n_checks++; if (count !== 3'(q.size()) || err !== ERR_NONE) begin
                n_fail++; $display("FAIL rnd_cnt%0d got cnt=%0d err=%0d want %0d/0", i, count, err, q.size());
            end
            if (q.size() > 0) begin
                n_checks++; if (front_data !== q[0] || back_data !== q[$]) begin
                    n_fail++; $display("FAIL rnd_peek%0d got f=%0d b=%0d want %0d/%0d", i, front_data, back_data, q[0], q[$]);
                end
            end
        end
    endtask

    initial begin
        our_reset = 0; clear = 0;
        push_back = 0; push_front = 0;
        pop_back = 0; pop_front = 0; din = 0;
        @(posedge Clk); #1;
        test_reset();
        test_fifo();
        test_full();
        test_underflow();
        test_wrap_illegal();
        test_reset_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
